// File: rtl/hw_frame_reader.sv
// hw_frame_reader
//   Streams one stored frame out of a block-RAM frame buffer as AXI4-Stream
//   video (tuser = start of frame, tlast = end of line). Reads are issued
//   against a credit limit so the output skid FIFO can absorb every pixel
//   still in the BRAM read pipeline under arbitrary tready backpressure.
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   start, busy, done    frame request / in progress / one-cycle completion
//   addr, clk, din, dout, en, rst, we
//                        BRAM read-port interface (write side tied off)
//   m_axis_*             AXI4-Stream video master
module hw_frame_reader #(
  parameter int unsigned AWIDTH       = 17,
  parameter int unsigned DWIDTH       = 16,
  parameter int unsigned WE_WIDTH     = 2,
  parameter int unsigned FRAME_WIDTH  = 320,
  parameter int unsigned FRAME_HEIGHT = 240,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [AWIDTH-1:0]   addr,
  output logic                clk,
  output logic [DWIDTH-1:0]   din,
  input  logic [DWIDTH-1:0]   dout,
  output logic                en,
  output logic                rst,
  output logic [WE_WIDTH-1:0] we,
  output logic [DWIDTH-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast
);

  localparam int unsigned XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [XW-1:0] X_LAST  = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state_q, state_d;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [YW-1:0] oy_q;

  logic [RD_LATENCY-1:0] pipe_v;
  logic [RD_LATENCY-1:0] pipe_sof;
  logic [RD_LATENCY-1:0] pipe_eol;

  logic [DWIDTH+1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     inflight;
  logic [DWIDTH+1:0] head;

  logic accept, push, pop, last_pix, last_beat, credit_ok;

  assign clk = aclk;
  assign din = '0;
  assign rst = 1'b0;
  assign we  = '0;

  // Entries already buffered plus reads still in the BRAM pipeline may never
  // exceed the FIFO size; this is what makes backpressure lossless.
  assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_C;
  assign en        = (state_q == READ) && credit_ok;
  assign accept    = (state_q == IDLE) && start && !done;
  assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign push      = pipe_v[RD_LATENCY-1];

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (fifo_cnt != '0);
  // Stale FIFO contents are masked so idle/reset outputs read as zero.
  assign m_axis_tdata  = m_axis_tvalid ? head[DWIDTH+1:2] : '0;
  assign m_axis_tuser  = m_axis_tvalid & head[1];
  assign m_axis_tlast  = m_axis_tvalid & head[0];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign last_beat     = (state_q == DRAIN) && pop && head[0] && (oy_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (en && last_pix) state_d = DRAIN;
      DRAIN:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      addr    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      oy_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= last_beat;
      if (accept) begin
        busy <= 1'b1;
        addr <= AWIDTH'(BASE_ADDR);
        x_q  <= '0;
        y_q  <= '0;
        oy_q <= '0;
      end else begin
        if (en) begin
          addr <= addr + 1'b1;
          if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        if (pop && head[0]) oy_q <= oy_q + 1'b1;
        if (last_beat) busy <= 1'b0;
      end
    end
  end

  // Position tags travel with the valid bit so they meet their BRAM data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pipe_v   <= '0;
      pipe_sof <= '0;
      pipe_eol <= '0;
    end else begin
      pipe_v[0]   <= en;
      pipe_sof[0] <= (x_q == '0) && (y_q == '0);
      pipe_eol[0] <= (x_q == X_LAST);
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_sof[i] <= pipe_sof[i-1];
        pipe_eol[i] <= pipe_eol[i-1];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      inflight <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({en, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {dout, pipe_sof[RD_LATENCY-1], pipe_eol[RD_LATENCY-1]};
  end

endmodule

// File: tb/tb_hw_frame_reader.sv
// Testbench for hw_frame_reader: three instances on a 4x3 frame
// (latency 2 / base 0, latency 1 / base 100, latency 4 / base 100), each
// fed by a BRAM model whose word at every address equals that address.
module tb_hw_frame_reader;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  logic        start    [3];
  logic        tready   [3];
  logic        busy_s   [3];
  logic        done_s   [3];
  logic [16:0] addr_s   [3];
  logic        clk_s    [3];
  logic [15:0] din_s    [3];
  logic        en_s     [3];
  logic        rst_s    [3];
  logic [1:0]  we_s     [3];
  logic [15:0] tdata_s  [3];
  logic        tvalid_s [3];
  logic        tuser_s  [3];
  logic        tlast_s  [3];

  int vectors     = 0;
  int miscompares = 0;

  int r_beats, r_first_valid, r_first_acc, r_last_acc, r_done_k;
  int r_first_addr, r_last_addr;

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT  = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam int unsigned BASE = (g == 0) ? 0 : 100;
    logic [15:0] rd_pipe [LAT];

    hw_frame_reader #(
      .AWIDTH(17), .DWIDTH(16), .WE_WIDTH(2),
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
      .BASE_ADDR(BASE), .RD_LATENCY(LAT), .FIFO_DEPTH(8)
    ) u_dut (
      .aclk(aclk), .aresetn(aresetn), .start(start[g]),
      .busy(busy_s[g]), .done(done_s[g]), .addr(addr_s[g]),
      .clk(clk_s[g]), .din(din_s[g]), .dout(rd_pipe[LAT-1]),
      .en(en_s[g]), .rst(rst_s[g]), .we(we_s[g]),
      .m_axis_tdata(tdata_s[g]), .m_axis_tvalid(tvalid_s[g]),
      .m_axis_tready(tready[g]), .m_axis_tuser(tuser_s[g]),
      .m_axis_tlast(tlast_s[g])
    );

    // BRAM read port: registered output after LAT cycles, contents = address.
    always @(posedge aclk) begin
      if (en_s[g] === 1'b1) rd_pipe[0] <= addr_s[g][15:0];
      for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  function automatic int base_of(input int g);
    return (g == 0) ? 0 : 100;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  // mode 0: tready=1, 1: random tready, 2: random + 20-cycle stall,
  // 3: tready=1 with extra start pulses, 4: reset after beat 5.
  // Caller is at a negedge; returns at a negedge.
  task automatic run_frame(input int g, input int mode);
    int idx, hold_cnt, issued;
    bit fin, stall, tr;
    logic [15:0] pd, exp_d;
    logic pu, pl;
    idx = 0; hold_cnt = 0; issued = 0; fin = 0; stall = 0;
    pd = '0; pu = 1'b0; pl = 1'b0;
    r_first_valid = -1; r_first_acc = -1; r_last_acc = -1; r_done_k = -1;
    r_first_addr = -1; r_last_addr = -1;
    start[g] = 1'b1;
    @(negedge aclk);
    start[g] = 1'b0;
    for (int k = 0; k < 400 && !fin; k++) begin
      if (mode == 4 && idx == 6) begin
        aresetn = 1'b0;
        #1;
        vectors++;
        if (addr_s[g] !== '0 || en_s[g] !== 1'b0 || busy_s[g] !== 1'b0 || done_s[g] !== 1'b0 ||
            tvalid_s[g] !== 1'b0 || tuser_s[g] !== 1'b0 || tlast_s[g] !== 1'b0 || tdata_s[g] !== '0)
          begin
            miscompares++;
            $display("FAIL mid_reset_outputs: addr=%0d en=%b busy=%b done=%b tvalid=%b tuser=%b tlast=%b tdata=%0d, required all 0",
                     addr_s[g], en_s[g], busy_s[g], done_s[g], tvalid_s[g], tuser_s[g], tlast_s[g], tdata_s[g]);
          end
        #2;
        aresetn = 1'b1;
        tready[g] = 1'b0;
        fin = 1;
      end else begin
        vectors++;
        if (we_s[g] !== 2'b00 || din_s[g] !== 16'h0 || rst_s[g] !== 1'b0 || clk_s[g] !== aclk) begin
          miscompares++;
          $display("FAIL constants: we=%b din=%h rst=%b clk=%b aclk=%b, required 0/0/0/aclk",
                   we_s[g], din_s[g], rst_s[g], clk_s[g], aclk);
        end
        if (en_s[g] === 1'b1) begin
          if (issued == 0) r_first_addr = int'(addr_s[g]);
          r_last_addr = int'(addr_s[g]);
          issued++;
        end
        if (tvalid_s[g] === 1'b1 && r_first_valid < 0) r_first_valid = k;
        if (stall) begin
          vectors++;
          if (tvalid_s[g] !== 1'b1 || tdata_s[g] !== pd || tuser_s[g] !== pu || tlast_s[g] !== pl) begin
            miscompares++;
            $display("FAIL stall_stable: tvalid=%b tdata=%0d tuser=%b tlast=%b, required 1/%0d/%b/%b",
                     tvalid_s[g], tdata_s[g], tuser_s[g], tlast_s[g], pd, pu, pl);
          end
        end
        vectors++;
        if (done_s[g] === 1'b1) begin
          r_done_k = k;
          fin = 1;
          if (busy_s[g] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_with_done: busy=%b, required 0", busy_s[g]);
          end
        end else if (busy_s[g] !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_during_frame: busy=%b at cycle %0d, required 1", busy_s[g], k);
        end
        if (mode == 0 || mode == 3) tr = 1'b1;
        else tr = ($urandom_range(0, 1) == 1);
        if (mode == 2 && idx >= 2 && hold_cnt < 20) begin
          tr = 1'b0;
          hold_cnt++;
          if (hold_cnt == 20) begin
            vectors++;
            if (en_s[g] !== 1'b0 || issued - idx != 8) begin
              miscompares++;
              $display("FAIL outstanding_limit: en=%b outstanding=%0d, required en=0 outstanding=8",
                       en_s[g], issued - idx);
            end
          end
        end
        tready[g] = tr;
        if (tvalid_s[g] === 1'b1 && tr) begin
          vectors++;
          exp_d = 16'(base_of(g) + idx);
          if (idx >= N || tdata_s[g] !== exp_d || tuser_s[g] !== (idx == 0) || tlast_s[g] !== (idx % W == W - 1)) begin
            miscompares++;
            $display("FAIL beat_%0d: tdata=%0d tuser=%b tlast=%b, required %0d/%b/%b",
                     idx, tdata_s[g], tuser_s[g], tlast_s[g], exp_d, idx == 0, idx % W == W - 1);
          end
          if (r_first_acc < 0) r_first_acc = k;
          r_last_acc = k;
          idx++;
        end
        stall = (tvalid_s[g] === 1'b1) && !tr;
        pd = tdata_s[g]; pu = tuser_s[g]; pl = tlast_s[g];
        start[g] = (mode == 3) && (k == 4 || done_s[g] === 1'b1);
      end
      @(negedge aclk);
    end
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: beats=%0d, required done within 400 cycles", idx);
    end
    r_beats = idx;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (addr_s[g] !== '0 || en_s[g] !== 1'b0 || busy_s[g] !== 1'b0 || done_s[g] !== 1'b0 ||
          tvalid_s[g] !== 1'b0 || tuser_s[g] !== 1'b0 || tlast_s[g] !== 1'b0)
        begin
          miscompares++;
          $display("FAIL reset_outputs[%0d]: addr=%0d en=%b busy=%b done=%b tvalid=%b, required all 0",
                   g, addr_s[g], en_s[g], busy_s[g], done_s[g], tvalid_s[g]);
        end
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_basic();
    run_frame(0, 0);
    vectors++;
    if (r_beats != N || r_first_valid != 3 || r_last_acc - r_first_acc != N - 1 || r_done_k != r_last_acc + 1) begin
      miscompares++;
      $display("FAIL basic_timing: beats=%0d first_valid=%0d span=%0d done_k=%0d, required %0d/3/%0d/%0d",
               r_beats, r_first_valid, r_last_acc - r_first_acc, r_done_k, N, N - 1, r_last_acc + 1);
    end
    vectors++;
    if (r_first_addr != 0 || r_last_addr != N - 1) begin
      miscompares++;
      $display("FAIL basic_addr: first=%0d last=%0d, required 0/%0d", r_first_addr, r_last_addr, N - 1);
    end
    vectors++;
    if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse_width: done=%b busy=%b after pulse, required 0/0", done_s[0], busy_s[0]);
    end
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 2; m++) begin
      run_frame(0, m);
      vectors++;
      if (r_beats != N || r_done_k != r_last_acc + 1) begin
        miscompares++;
        $display("FAIL backpressure_mode%0d: beats=%0d done_k=%0d, required %0d/%0d",
                 m, r_beats, r_done_k, N, r_last_acc + 1);
      end
    end
  endtask

  task automatic test_latency();
    for (int g = 1; g <= 2; g++) begin
      run_frame(g, 0);
      vectors++;
      if (r_beats != N || r_first_addr != 100 || r_last_addr != 111 || r_first_valid != lat_of(g) + 1) begin
        miscompares++;
        $display("FAIL latency_%0d: beats=%0d first_addr=%0d last_addr=%0d first_valid=%0d, required %0d/100/111/%0d",
                 lat_of(g), r_beats, r_first_addr, r_last_addr, r_first_valid, N, lat_of(g) + 1);
      end
    end
  endtask

  task automatic test_start_busy();
    run_frame(0, 3);
    vectors++;
    if (r_beats != N || r_first_valid != 3) begin
      miscompares++;
      $display("FAIL start_busy: beats=%0d first_valid=%0d, required %0d/3", r_beats, r_first_valid, N);
    end
    run_frame(0, 0);
    vectors++;
    if (r_beats != N || r_first_valid != 3) begin
      miscompares++;
      $display("FAIL start_after_done: beats=%0d first_valid=%0d, required %0d/3", r_beats, r_first_valid, N);
    end
  endtask

  task automatic test_reset_mid();
    run_frame(0, 4);
    vectors++;
    if (r_beats != 6 || r_done_k != -1) begin
      miscompares++;
      $display("FAIL mid_reset_abort: beats=%0d done_k=%0d, required 6/-1", r_beats, r_done_k);
    end
    run_frame(0, 1);
    vectors++;
    if (r_beats != N || r_first_valid != 3) begin
      miscompares++;
      $display("FAIL restart_after_reset: beats=%0d first_valid=%0d, required %0d/3", r_beats, r_first_valid, N);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      start[g]  = 1'b0;
      tready[g] = 1'b0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_latency();
    test_start_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hw_frame_reader.md
Name: hw_frame_reader

Overview:
- Reads one stored camera frame out of the block-RAM frame buffer and streams it as AXI4-Stream video: tuser marks start-of-frame, tlast marks end-of-line.
- Sits on the read port of the same block memory that the OV7670 capture path writes.
- Feeds downstream vision and DMA logic. Tolerates arbitrary tready backpressure against a fixed BRAM read latency.

Parameters:
- AWIDTH, 17, BRAM address width.
- DWIDTH, 16, BRAM and pixel data width (RGB565).
- WE_WIDTH, 2, BRAM byte-write-enable width.
- FRAME_WIDTH, 320, pixels per line.
- FRAME_HEIGHT, 240, lines per frame.
- BASE_ADDR, 0, BRAM address of pixel (0,0).
- RD_LATENCY, 2, cycles from en/addr to valid dout (1..4).
- FIFO_DEPTH, 8, output skid FIFO entries; must be >= RD_LATENCY+2, power of 2.

Ports:
- aclk, in, 1, sole clock.
- aresetn, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle request to stream one frame.
- busy, out, 1, high from accepted start until last beat is accepted.
- done, out, 1, one-cycle pulse after last beat is accepted.
- addr, out, AWIDTH, BRAM read address.
- clk, out, 1, BRAM clock, equal to aclk.
- din, out, DWIDTH, BRAM write data, constant 0.
- dout, in, DWIDTH, BRAM read data.
- en, out, 1, BRAM enable, one read per asserted cycle.
- rst, out, 1, BRAM reset, constant 0.
- we, out, WE_WIDTH, BRAM write enable, constant 0.
- m_axis_tdata, out, DWIDTH, pixel.
- m_axis_tvalid, out, 1, beat valid.
- m_axis_tready, in, 1, sink ready.
- m_axis_tuser, out, 1, high on pixel (0,0) only.
- m_axis_tlast, out, 1, high on pixel x = FRAME_WIDTH-1.

Behaviour:
- Reset: all outputs 0 (addr=0, en=0, busy=0, done=0, tvalid=0, tuser=0, tlast=0). FSM to IDLE; FIFO, counters and in-flight tags cleared.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: when start=1, set busy=1, load addr=BASE_ADDR, x=y=0, go to READ.
  - READ: issue reads. After the read for pixel (W-1,H-1) is issued, go to DRAIN.
  - DRAIN: when the last beat is accepted (tvalid&tready&tlast with y=H-1), pulse done for 1 cycle, set busy=0 on the same cycle, go to IDLE.
- start is ignored while busy=1. start on the cycle done is pulsed is also ignored; a new start is taken from the next cycle.
- Read issue:
  - en=1 in a cycle iff state=READ and (fifo_count + inflight) < FIFO_DEPTH.
  - addr advances by 1 after each issued read.
  - x wraps at FRAME_WIDTH-1, which increments y.
  - Address arithmetic is unsigned modulo 2^AWIDTH; BASE_ADDR+W*H-1 must fit (76800 entries at default).
- Tag pipeline:
  - Each issued read pushes {sof,eol} through a RD_LATENCY-deep shift register alongside the valid bit.
  - When the valid bit emerges, {dout,sof,eol} are written into the FIFO on that cycle.
- inflight counter: +1 on issue, -1 on FIFO write; both in the same cycle leaves it unchanged.
- Output:
  - FIFO head drives tdata/tuser/tlast; tvalid = FIFO not empty.
  - Pop on tvalid&tready.
  - AXIS rule: once tvalid=1, tdata/tuser/tlast stay stable until accepted.
  - tvalid never deasserts without acceptance.
- Full/empty:
  - The credit rule guarantees the FIFO never overflows; no BRAM data is ever dropped.
  - If tready is held low indefinitely, en stops after FIFO_DEPTH outstanding reads.
  - Simultaneous FIFO push and pop when full-minus-one or empty is legal; count is unchanged.
- Throughput: with tready=1 continuously, one beat per cycle. First tvalid arrives RD_LATENCY+1 cycles after start.
- Mid-frame reset: everything returns to reset values immediately; in-flight reads and buffered pixels are discarded; no done pulse.

Test Plan:
- Basic frame: FRAME_WIDTH=4, FRAME_HEIGHT=3, BRAM holds addr value at each entry, tready=1, start pulse -> 12 beats with tdata 0..11 on consecutive cycles; tuser only on beat 0; tlast on beats 3,7,11; done pulse 1 cycle after beat 11; busy low with done.
- Backpressure: same frame with tready toggled by random 50% pattern and held low for 20 cycles -> identical ordered data; en deasserts with exactly FIFO_DEPTH outstanding; no lost or duplicated beat; tdata stable while tvalid&!tready.
- Latency sweep: RD_LATENCY=1 and 4, BASE_ADDR=100 -> first addr=100; first tvalid at cycle RD_LATENCY+1 after start; last addr=111.
- Start while busy: extra start pulses mid-frame and on the done cycle -> ignored, exactly 12 beats; a start 1 cycle after done begins a new frame with tuser.
- Reset mid-frame: aresetn low after beat 5 -> all outputs 0 asynchronously; after release and start, frame restarts at tdata 0 with tuser.
- Constant outputs: across all scenarios we=0, din=0, rst=0, and clk follows aclk.
